// File: rtl/game_pkg.sv
// Shared types and constants for the pixel game: jump FSM states and dino row encoding.
package game_pkg;

   typedef enum logic [1:0] {
      GROUND   = 2'd0,
      AIR      = 2'd1,
      COOLDOWN = 2'd2
   } jump_state_e;

   localparam logic ROW_GROUND = 1'b0;
   localparam logic ROW_AIR    = 1'b1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: multi-flop synchroniser, restartable debounce counter and
// a registered one-cycle pulse on each accepted rising edge.
module btn_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic btn_clean_o,
   output logic btn_press_o
);

   localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   press_q, press_d;
   logic                   btn_sync;

   assign btn_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_d   = '0;
      clean_d = clean_q;
      press_d = 1'b0;
      // Any cycle that agrees with the accepted level restarts the count.
      if (btn_sync != clean_q) begin
         if (cnt_q == CntMax) begin
            clean_d = btn_sync;
            press_d = btn_sync;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         press_q <= press_d;
      end
   end

   assign btn_clean_o = clean_q;
   assign btn_press_o = press_q;

endmodule

// File: rtl/jump_controller.sv
// Turns debounced jump presses into tick-aligned jumps: AIR_TICKS on row 1, then an
// optional cooldown on row 0 before the next jump may start.
module jump_controller
   import game_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned AIR_TICKS       = 3,
   parameter int unsigned COOLDOWN_TICKS  = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       jump_button_i,
   input  logic       tick_i,
   output logic       btn_clean_o,
   output logic       btn_press_o,
   output logic       dino_row_o,
   output logic       jump_active_o,
   output logic [7:0] jump_count_o
);

   localparam int unsigned      TickW   = 4;
   localparam logic [TickW-1:0] AirInit = TickW'(AIR_TICKS);
   localparam logic [TickW-1:0] CdInit  = TickW'(COOLDOWN_TICKS);

   logic             btn_press;
   jump_state_e      state_q;
   logic [TickW-1:0] air_cnt_q, cd_cnt_q;
   logic             pending_q, dino_row_q, active_q;
   logic [7:0]       count_q;

   btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .btn_i      (jump_button_i),
      .btn_clean_o(btn_clean_o),
      .btn_press_o(btn_press)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= GROUND;
         air_cnt_q  <= '0;
         cd_cnt_q   <= '0;
         pending_q  <= 1'b0;
         dino_row_q <= ROW_GROUND;
         active_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         // Presses outside GROUND are dropped rather than queued.
         if (btn_press && state_q == GROUND) pending_q <= 1'b1;
         if (tick_i) begin
            unique case (state_q)
               GROUND: begin
                  if (pending_q) begin
                     state_q    <= AIR;
                     dino_row_q <= ROW_AIR;
                     active_q   <= 1'b1;
                     air_cnt_q  <= AirInit;
                     pending_q  <= 1'b0;
                     count_q    <= sat_inc8(count_q);
                  end
               end
               AIR: begin
                  if (air_cnt_q == TickW'(1)) begin
                     dino_row_q <= ROW_GROUND;
                     if (COOLDOWN_TICKS == 0) begin
                        state_q  <= GROUND;
                        active_q <= 1'b0;
                     end else begin
                        state_q  <= COOLDOWN;
                        cd_cnt_q <= CdInit;
                     end
                  end else begin
                     air_cnt_q <= air_cnt_q - TickW'(1);
                  end
               end
               COOLDOWN: begin
                  if (cd_cnt_q == TickW'(1)) begin
                     state_q  <= GROUND;
                     active_q <= 1'b0;
                  end else begin
                     cd_cnt_q <= cd_cnt_q - TickW'(1);
                  end
               end
               default: begin
                  state_q  <= GROUND;
                  active_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign btn_press_o   = btn_press;
   assign dino_row_o    = dino_row_q;
   assign jump_active_o = active_q;
   assign jump_count_o  = count_q;

endmodule
